clock_adjust_ctrl: RTL and testbench
====================================

# clock_adjust_ctrl

Parametrised time-set controller for the digital clock: an N-field generalisation of the fixed seconds/minutes/hours set-mode state machine. It takes the debounced MODE/SELECT pulses and the ADJUST key level and produces per-field increment/clear pulses and per-field blink enables. It adds auto-repeat on a held ADJUST and an inactivity timeout back to normal mode. It sits between the key debouncers and the field counters, and drives the display blanking.

## Interface
- NFIELD, 3: number of adjustable fields; field 0 is the lowest (seconds).
- ENTRY, 0: field selected on entry to adjust mode (0..NFIELD-1).
- CLRMASK, 3'b001 (NFIELD bits): bit i=1 means ADJUST clears field i instead of incrementing it.
- REP_DLY, 8: TICK pulses of continuous ADJUST hold before the first repeat.
- REP_RATE, 2: TICK pulses between subsequent repeats.
- TIMEOUT, 64: TICK pulses without key activity before returning to normal mode; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- TICK  in  1  one-cycle timebase pulse (e.g. 8 Hz) for repeat and timeout.
- SIG2HZ  in  1  blink square wave.
- MODE  in  1  one-cycle pulse; toggles normal/adjust.
- SELECT  in  1  one-cycle pulse; steps the selected field.
- ADJUST  in  1  debounced key level.
- INC  out  NFIELD  one-cycle increment pulse per field.
- CLR  out  NFIELD  one-cycle clear pulse per field.
- ON  out  NFIELD  display enable per field; 0 = blanked.
- ADJMODE  out  1  high while in adjust mode.
- FIELD  out  $clog2(NFIELD) (min 1)  selected field index.

## Operation
- States: NORM, ADJ. The field index register `sel` is valid in ADJ.
- NORM: MODE=1 moves to ADJ with sel=ENTRY. SELECT and ADJUST are ignored.
- ADJ, per-cycle priority MODE > SELECT > ADJUST:
  - MODE moves to NORM.
  - SELECT sets sel = (sel==0) ? NFIELD-1 : sel-1. With the defaults this gives the cycle 0→2→1→0.
  - ADJUST rising edge (ADJUST=1, registered previous value=0) fires one action on field sel: CLR[sel] if CLRMASK[sel], else INC[sel]. It also sets the `armed` flag.
- Auto-repeat:
  - Applies only while armed, ADJUST=1, and the selected field is not in CLRMASK.
  - Counts TICK pulses. After REP_DLY ticks it emits INC[sel]; after that, one INC every REP_RATE ticks.
  - Deasserting ADJUST clears armed, the counter and the phase.
  - MODE or SELECT also clears armed and the counter. Repeat then resumes only after a new rising edge.
- Timeout:
  - The counter in ADJ clears on any cycle with MODE, SELECT or ADJUST=1; otherwise it increments on TICK.
  - Reaching TIMEOUT moves to NORM.
  - The counter is held at 0 in NORM or when TIMEOUT=0.
- ADJMODE = (state==ADJ). FIELD = sel.
- ON[i] = ~(state==ADJ & sel==i & SIG2HZ & ~ADJUST). The field is not blinked while the key is held.
- Counter widths are $clog2 of max(REP_DLY, REP_RATE)+1 and TIMEOUT+1. Counters never wrap: they clear when they fire.

## Timing
- Reset values: state=NORM, sel=ENTRY, all counters 0, armed=0. Outputs: INC=0, CLR=0, ON=all 1, ADJMODE=0, FIELD=ENTRY.
- State, sel, INC and CLR are registered:
  - MODE/SELECT sampled at edge t updates ADJMODE/FIELD after edge t.
  - An ADJUST rising edge sampled at t gives an INC/CLR pulse high for exactly the cycle after t.
- ON is combinational from registered state and sel plus the SIG2HZ/ADJUST inputs.
- Nth repeat pulse: high in the cycle after the TICK that completes the count.
- Timeout exit: ADJMODE falls in the cycle after the TICK that reaches TIMEOUT.
- Simultaneous events:
  - MODE with ADJUST edge: mode change only, no pulse.
  - SELECT with ADJUST edge: field steps, no pulse.
  - TICK with key activity: the timeout counter clears.
- At most one bit of INC|CLR is high in any cycle.
- RST mid-repeat or mid-ADJ: reset values apply in the next cycle, with no pulse emitted.

## Test plan
All scenarios use NFIELD=3, ENTRY=0, CLRMASK=001, REP_DLY=4, REP_RATE=2, TIMEOUT=8.
- Reset then idle 20 cycles: ADJMODE=0, FIELD=0, ON=111, INC=CLR=000 throughout.
- MODE; SELECT×3: FIELD reads 0, 2, 1, 0. With SIG2HZ=1 and FIELD=2, ON=011. A second MODE gives ADJMODE=0 and ON=111.
- MODE, then ADJUST pulsed on field 0: exactly one CLR=001 cycle. Held for 20 TICKs on field 0: no further pulses.
- MODE, SELECT (FIELD=2), ADJUST held for 10 TICKs: INC=100 once on the edge, then after TICKs 4, 6, 8 and 10, giving 5 pulses total. ON[2] stays 1 while held.
- MODE, then no keys for 8 TICKs: ADJMODE falls after the 8th TICK. Repeat with a SELECT at TICK 5: the exit moves to TICK 13.
- ADJUST held while repeating, then RST: INC=000 and all reset values the next cycle. Releasing RST with ADJUST still high produces no pulse in NORM.

Source files
------------

// File: rtl/clock_adjust_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | clock_adjust_ctrl_if : key inputs and field control outputs of the       |
// | time-set controller.                                Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface clock_adjust_ctrl_if #(
  parameter int NFIELD = 3
);
  localparam int FW = (NFIELD > 1) ? $clog2(NFIELD) : 1;

  logic              tick;
  logic              sig2hz;
  logic              mode;
  logic              select;
  logic              adjust;
  logic [NFIELD-1:0] inc;
  logic [NFIELD-1:0] clr;
  logic [NFIELD-1:0] on;
  logic              adjmode;
  logic [FW-1:0]     field;

  modport master (
    output tick, sig2hz, mode, select, adjust,
    input  inc, clr, on, adjmode, field
  );

  modport slave (
    input  tick, sig2hz, mode, select, adjust,
    output inc, clr, on, adjmode, field
  );
endinterface

`default_nettype wire

// File: rtl/clock_adjust_ctrl.sv
// +--------------------------------------------------------------------------+
// | clock_adjust_ctrl : N-field time-set controller with auto-repeat and     |
// | inactivity timeout.                                 Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module clock_adjust_ctrl #(
  parameter int                NFIELD   = 3,
  parameter int                ENTRY    = 0,
  parameter logic [NFIELD-1:0] CLRMASK  = NFIELD'(1),
  parameter int                REP_DLY  = 8,
  parameter int                REP_RATE = 2,
  parameter int                TIMEOUT  = 64
) (
  input wire logic           clk,
  input wire logic           rst,
  clock_adjust_ctrl_if.slave bus
);

  localparam int FW      = (NFIELD > 1) ? $clog2(NFIELD) : 1;
  localparam int REP_MAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
  localparam int RW      = (REP_MAX > 0) ? $clog2(REP_MAX + 1) : 1;
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [FW-1:0] ENTRY_SEL = FW'(ENTRY);
  localparam logic [FW-1:0] LAST_SEL  = FW'(NFIELD - 1);
  localparam logic [RW-1:0] DLY_LIM   = RW'(REP_DLY);
  localparam logic [RW-1:0] RATE_LIM  = RW'(REP_RATE);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT);

  typedef enum logic [0:0] {
    NORM = 1'b0,
    ADJ  = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [FW-1:0]     sel, sel_nx;
  logic              adj_prev;
  logic              armed, armed_nx;
  logic              phase, phase_nx;
  logic [RW-1:0]     rep_cnt, rep_cnt_nx;
  logic [TW-1:0]     tmo_cnt, tmo_cnt_nx;
  logic [NFIELD-1:0] inc_q, inc_nx;
  logic [NFIELD-1:0] clr_q, clr_nx;

  logic [NFIELD-1:0] sel_oh;
  logic              sel_is_clr;
  logic              adj_rise;
  logic [RW-1:0]     rep_lim;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NFIELD; i++) begin
      sel_oh[i] = (sel == FW'(i));
    end
    sel_is_clr = |(sel_oh & CLRMASK);
    adj_rise   = bus.adjust & ~adj_prev;
    // phase=0 waits for the initial hold delay, phase=1 for the repeat rate
    rep_lim    = phase ? RATE_LIM : DLY_LIM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NORM;
      sel      <= ENTRY_SEL;
      adj_prev <= 1'b0;
      armed    <= 1'b0;
      phase    <= 1'b0;
      rep_cnt  <= '0;
      tmo_cnt  <= '0;
      inc_q    <= '0;
      clr_q    <= '0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      adj_prev <= bus.adjust;
      armed    <= armed_nx;
      phase    <= phase_nx;
      rep_cnt  <= rep_cnt_nx;
      tmo_cnt  <= tmo_cnt_nx;
      inc_q    <= inc_nx;
      clr_q    <= clr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    armed_nx   = armed;
    phase_nx   = phase;
    rep_cnt_nx = rep_cnt;
    tmo_cnt_nx = tmo_cnt;
    inc_nx     = '0;
    clr_nx     = '0;

    case (state)
      NORM: begin
        armed_nx   = 1'b0;
        phase_nx   = 1'b0;
        rep_cnt_nx = '0;
        tmo_cnt_nx = '0;
        if (bus.mode) begin
          state_nx = ADJ;
          sel_nx   = ENTRY_SEL;
        end
      end

      ADJ: begin
        if (bus.mode) begin
          state_nx   = NORM;
          armed_nx   = 1'b0;
          phase_nx   = 1'b0;
          rep_cnt_nx = '0;
        end else if (bus.select) begin
          sel_nx     = (sel == '0) ? LAST_SEL : sel - 1'b1;
          armed_nx   = 1'b0;
          phase_nx   = 1'b0;
          rep_cnt_nx = '0;
        end else if (adj_rise) begin
          if (sel_is_clr) clr_nx = sel_oh;
          else            inc_nx = sel_oh;
          armed_nx   = 1'b1;
          phase_nx   = 1'b0;
          rep_cnt_nx = '0;
        end else if (!bus.adjust) begin
          armed_nx   = 1'b0;
          phase_nx   = 1'b0;
          rep_cnt_nx = '0;
        end else if (armed && !sel_is_clr && bus.tick) begin
          if (rep_cnt + 1'b1 == rep_lim) begin
            inc_nx     = sel_oh;
            phase_nx   = 1'b1;
            rep_cnt_nx = '0;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end

        // Any key activity restarts the inactivity window, even on a TICK cycle
        if (TIMEOUT == 0 || bus.mode || bus.select || bus.adjust) begin
          tmo_cnt_nx = '0;
        end else if (bus.tick) begin
          if (tmo_cnt + 1'b1 == TMO_LIM) begin
            state_nx   = NORM;
            tmo_cnt_nx = '0;
          end else begin
            tmo_cnt_nx = tmo_cnt + 1'b1;
          end
        end
      end

      default: state_nx = NORM;
    endcase
  end

  assign bus.inc     = inc_q;
  assign bus.clr     = clr_q;
  assign bus.adjmode = (state == ADJ);
  assign bus.field   = sel;

  generate
    for (genvar i = 0; i < NFIELD; i++) begin : g_on
      assign bus.on[i] = ~((state == ADJ) & (sel == FW'(i)) & bus.sig2hz & ~bus.adjust);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_adjust_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_clock_adjust_ctrl : directed self-checking bench for clock_adjust_ctrl|
// |                                                     Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_clock_adjust_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  clock_adjust_ctrl_if #(.NFIELD(3)) bus ();

  clock_adjust_ctrl #(
    .NFIELD  (3),
    .ENTRY   (0),
    .CLRMASK (3'b001),
    .REP_DLY (4),
    .REP_RATE(2),
    .TIMEOUT (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    bus.mode = 1'b1; step(); bus.mode = 1'b0;
  endtask

  task automatic pulse_select();
    bus.select = 1'b1; step(); bus.select = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b1;
    step(); step();
    got = {bus.adjmode, bus.field, bus.on, bus.inc, bus.clr};
    n_checks++;
    if (got !== 13'b0_00_111_000_000) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", got, 13'b0_00_111_000_000);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      got = {bus.adjmode, bus.field, bus.on, bus.inc, bus.clr};
      n_checks++;
      if (got !== 13'b0_00_111_000_000) begin
        n_fail++; $display("FAIL idle_cycle%0d: got %b expected %b", k, got, 13'b0_00_111_000_000);
      end
    end
  endtask

  task automatic test_select();
    pulse_mode();
    n_checks++;
    if ({bus.adjmode, bus.field} !== 3'b1_00) begin
      n_fail++; $display("FAIL enter_adj: got %b expected %b", {bus.adjmode, bus.field}, 3'b100);
    end
    pulse_select();
    n_checks++;
    if (bus.field !== 2'd2) begin n_fail++; $display("FAIL select1: got %0d expected 2", bus.field); end
    bus.sig2hz = 1'b1; #1;
    n_checks++;
    if (bus.on !== 3'b011) begin n_fail++; $display("FAIL blink_f2: got %b expected 011", bus.on); end
    bus.sig2hz = 1'b0; #1;
    n_checks++;
    if (bus.on !== 3'b111) begin n_fail++; $display("FAIL blink_low: got %b expected 111", bus.on); end
    pulse_select();
    n_checks++;
    if (bus.field !== 2'd1) begin n_fail++; $display("FAIL select2: got %0d expected 1", bus.field); end
    pulse_select();
    n_checks++;
    if (bus.field !== 2'd0) begin n_fail++; $display("FAIL select3: got %0d expected 0", bus.field); end
    pulse_mode();
    bus.sig2hz = 1'b1; #1;
    n_checks++;
    if ({bus.adjmode, bus.on} !== 4'b0_111) begin
      n_fail++; $display("FAIL exit_adj: got %b expected %b", {bus.adjmode, bus.on}, 4'b0111);
    end
    bus.sig2hz = 1'b0;
  endtask

  task automatic test_clear();
    int pulses = 0;
    pulse_mode();
    bus.adjust = 1'b1;
    step();
    n_checks++;
    if ({bus.clr, bus.inc} !== 6'b001_000) begin
      n_fail++; $display("FAIL clear_edge: got clr/inc %b expected %b", {bus.clr, bus.inc}, 6'b001000);
    end
    bus.sig2hz = 1'b1; #1;
    n_checks++;
    if (bus.on !== 3'b111) begin n_fail++; $display("FAIL held_no_blink: got %b expected 111", bus.on); end
    for (int k = 0; k < 20; k++) begin
      bus.tick = 1'b1; step(); bus.tick = 1'b0;
      if ((bus.inc | bus.clr) !== 3'b000) pulses++;
      step();
      if ((bus.inc | bus.clr) !== 3'b000) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL clear_no_repeat: got %0d pulses expected 0", pulses); end
    bus.adjust = 1'b0; bus.sig2hz = 1'b0;
    step();
    pulse_mode();
  endtask

  task automatic test_repeat();
    int          pulses = 0;
    logic [2:0]  exp;
    pulse_mode();
    pulse_select();
    bus.adjust = 1'b1; bus.sig2hz = 1'b1;
    step();
    n_checks++;
    if ({bus.inc, bus.clr} !== 6'b100_000) begin
      n_fail++; $display("FAIL repeat_edge: got inc/clr %b expected %b", {bus.inc, bus.clr}, 6'b100000);
    end
    if (bus.inc !== 3'b000) pulses++;
    for (int k = 1; k <= 10; k++) begin
      bus.tick = 1'b1; step(); bus.tick = 1'b0;
      exp = (k >= 4 && (k % 2) == 0) ? 3'b100 : 3'b000;
      n_checks++;
      if (bus.inc !== exp || bus.clr !== 3'b000) begin
        n_fail++; $display("FAIL repeat_tick%0d: got inc %b clr %b expected inc %b", k, bus.inc, bus.clr, exp);
      end
      if (bus.inc !== 3'b000) pulses++;
      n_checks++;
      if (bus.on !== 3'b111) begin n_fail++; $display("FAIL repeat_on%0d: got %b expected 111", k, bus.on); end
      step();
      n_checks++;
      if (bus.inc !== 3'b000) begin n_fail++; $display("FAIL repeat_gap%0d: got %b expected 000", k, bus.inc); end
    end
    n_checks++;
    if (pulses !== 5) begin n_fail++; $display("FAIL repeat_total: got %0d expected 5", pulses); end
    bus.adjust = 1'b0; bus.sig2hz = 1'b0;
    step();
    pulse_mode();
  endtask

  task automatic test_simultaneous();
    pulse_mode();
    bus.mode = 1'b1; bus.adjust = 1'b1;
    step();
    bus.mode = 1'b0; bus.adjust = 1'b0;
    n_checks++;
    if ({bus.adjmode, bus.inc, bus.clr} !== 7'b0_000_000) begin
      n_fail++; $display("FAIL mode_with_edge: got %b expected %b", {bus.adjmode, bus.inc, bus.clr}, 7'b0);
    end
    step();
    pulse_mode();
    bus.select = 1'b1; bus.adjust = 1'b1;
    step();
    bus.select = 1'b0;
    n_checks++;
    if ({bus.field, bus.inc, bus.clr} !== 8'b10_000_000) begin
      n_fail++; $display("FAIL select_with_edge: got %b expected %b", {bus.field, bus.inc, bus.clr}, 8'b10000000);
    end
    step();
    n_checks++;
    if ({bus.inc, bus.clr} !== 6'b0) begin
      n_fail++; $display("FAIL held_after_select: got %b expected 000000", {bus.inc, bus.clr});
    end
    bus.adjust = 1'b0; step();
    bus.adjust = 1'b1; step();
    n_checks++;
    if ({bus.inc, bus.clr} !== 6'b100_000) begin
      n_fail++; $display("FAIL new_edge_f2: got %b expected 100000", {bus.inc, bus.clr});
    end
    bus.adjust = 1'b0;
    step();
    pulse_mode();
  endtask

  task automatic test_timeout();
    logic exp;
    pulse_mode();
    for (int k = 1; k <= 8; k++) begin
      bus.tick = 1'b1; step(); bus.tick = 1'b0;
      exp = (k < 8);
      n_checks++;
      if (bus.adjmode !== exp) begin
        n_fail++; $display("FAIL timeout_tick%0d: got adjmode %b expected %b", k, bus.adjmode, exp);
      end
      step(); step();
    end
    pulse_mode();
    for (int k = 1; k <= 13; k++) begin
      bus.tick = 1'b1;
      if (k == 5) bus.select = 1'b1;
      step();
      bus.tick = 1'b0; bus.select = 1'b0;
      exp = (k < 13);
      n_checks++;
      if (bus.adjmode !== exp) begin
        n_fail++; $display("FAIL timeout_sel_tick%0d: got adjmode %b expected %b", k, bus.adjmode, exp);
      end
      step(); step();
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] got;
    pulse_mode();
    pulse_select();
    bus.adjust = 1'b1; bus.sig2hz = 1'b1;
    step();
    n_checks++;
    if (bus.inc !== 3'b100) begin n_fail++; $display("FAIL rmid_edge: got %b expected 100", bus.inc); end
    for (int k = 1; k <= 3; k++) begin
      bus.tick = 1'b1; step(); bus.tick = 1'b0; step();
    end
    bus.tick = 1'b1; rst = 1'b1;
    step();
    bus.tick = 1'b0;
    got = {bus.adjmode, bus.field, bus.on, bus.inc, bus.clr};
    n_checks++;
    if (got !== 13'b0_00_111_000_000) begin
      n_fail++; $display("FAIL rmid_reset: got %b expected %b", got, 13'b0_00_111_000_000);
    end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.tick = 1'b1; step(); bus.tick = 1'b0;
      n_checks++;
      if ({bus.adjmode, bus.inc, bus.clr} !== 7'b0) begin
        n_fail++; $display("FAIL rmid_norm%0d: got %b expected 0000000", k, {bus.adjmode, bus.inc, bus.clr});
      end
      step();
    end
    pulse_mode();
    n_checks++;
    if ({bus.adjmode, bus.field, bus.inc, bus.clr} !== 9'b1_00_000_000) begin
      n_fail++; $display("FAIL rmid_enter_held: got %b expected %b", {bus.adjmode, bus.field, bus.inc, bus.clr}, 9'b100000000);
    end
    bus.adjust = 1'b0; bus.sig2hz = 1'b0;
    step();
    pulse_mode();
  endtask

  initial begin
    bus.tick = 1'b0; bus.sig2hz = 1'b0; bus.mode = 1'b0;
    bus.select = 1'b0; bus.adjust = 1'b0;
    test_reset();
    test_select();
    test_clear();
    test_repeat();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
